// File: rtl/csr_write_sched_if.sv
// ---------------------------------------------------------------------------
// csr_write_sched_if
// Bundles the request, trap and CSR-file write signals of csr_write_sched.
//   slave  modport : scheduler view (csr_write_sched)
//   master modport : requester / environment view (pipeline, trap unit, file)
// Signal summary:
//   pipe_we/pipe_addr/pipe_din -> WB-stage CSR write request, pipe_stall back
//   trap_req/trap_pc/trap_cause/trap_tval -> trap entry, trap_ack/trap_done/busy back
//   csr_we/csr_waddr/csr_wdata -> CSR file write port
// Optional macro CSR_RAW_FWD_EN adds rd_addr/rd_din/rd_dout (same-cycle
// read-after-write forwarding for the ID stage).
// ---------------------------------------------------------------------------
interface csr_write_sched_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
);
   logic              pipe_we;
   logic [ADDR_W-1:0] pipe_addr;
   logic [DATA_W-1:0] pipe_din;
   logic              pipe_stall;
   logic              trap_req;
   logic [DATA_W-1:0] trap_pc;
   logic [DATA_W-1:0] trap_cause;
   logic [DATA_W-1:0] trap_tval;
   logic              trap_ack;
   logic              trap_done;
   logic              busy;
   logic              csr_we;
   logic [ADDR_W-1:0] csr_waddr;
   logic [DATA_W-1:0] csr_wdata;
`ifdef CSR_RAW_FWD_EN
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_din;
   logic [DATA_W-1:0] rd_dout;
`endif

   modport slave (
      input  pipe_we, pipe_addr, pipe_din,
      output pipe_stall,
      input  trap_req, trap_pc, trap_cause, trap_tval,
      output trap_ack, trap_done, busy,
      output csr_we, csr_waddr, csr_wdata
`ifdef CSR_RAW_FWD_EN
      ,
      input  rd_addr, rd_din,
      output rd_dout
`endif
   );

   modport master (
      output pipe_we, pipe_addr, pipe_din,
      input  pipe_stall,
      output trap_req, trap_pc, trap_cause, trap_tval,
      input  trap_ack, trap_done, busy,
      input  csr_we, csr_waddr, csr_wdata
`ifdef CSR_RAW_FWD_EN
      ,
      output rd_addr, rd_din,
      input  rd_dout
`endif
   );
endinterface

// File: rtl/csr_write_sched.sv
// ---------------------------------------------------------------------------
// csr_write_sched
// Arbitrates the single write port of the 4096x32 CSR file between the
// WB-stage CSR write and the trap unit's three-write sequence
// (mepc, mcause, mtval). The trap wins on contention; the pipeline write is
// stalled (never dropped), so writes land in request order.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : csr_write_sched_if.slave (pipe_*, trap_*, busy, csr_* signals)
// All csr_* outputs, trap_ack, trap_done and busy are registered;
// pipe_stall (and rd_dout when present) are combinational.
// Optional macro CSR_RAW_FWD_EN: adds rd_addr/rd_din/rd_dout forwarding of
// the value currently on the write port to the ID stage.
// ---------------------------------------------------------------------------
module csr_write_sched #(
   parameter int                ADDR_W      = 12,
   parameter int                DATA_W      = 32,
   parameter logic [ADDR_W-1:0] MEPC_ADDR   = 12'h341,
   parameter logic [ADDR_W-1:0] MCAUSE_ADDR = 12'h342,
   parameter logic [ADDR_W-1:0] MTVAL_ADDR  = 12'h343
) (
   input logic               clk,
   input logic               rst,
   csr_write_sched_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      W_EPC   = 2'd1,
      W_CAUSE = 2'd2,
      W_TVAL  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic              csr_we_q, csr_we_d;
   logic [ADDR_W-1:0] csr_waddr_q, csr_waddr_d;
   logic [DATA_W-1:0] csr_wdata_q, csr_wdata_d;
   logic              trap_ack_q, trap_ack_d;
   logic              trap_done_q, trap_done_d;
   logic              busy_q, busy_d;
   // The trap PC goes straight into csr_wdata_q on acceptance (it is the
   // first write), so only cause and tval need their own holding registers.
   logic [DATA_W-1:0] cause_q, cause_d;
   logic [DATA_W-1:0] tval_q, tval_d;

   // Next-state and registered-output computation for the write-port FSM
   always_comb begin
      state_d     = state_q;
      csr_we_d    = 1'b0;
      csr_waddr_d = csr_waddr_q;
      csr_wdata_d = csr_wdata_q;
      trap_ack_d  = 1'b0;
      trap_done_d = 1'b0;
      busy_d      = 1'b0;
      cause_d     = cause_q;
      tval_d      = tval_q;
      case (state_q)
         IDLE: begin
            if (bus.trap_req) begin
               // trap has priority; a simultaneous pipe write is stalled
               state_d     = W_EPC;
               cause_d     = bus.trap_cause;
               tval_d      = bus.trap_tval;
               csr_we_d    = 1'b1;
               csr_waddr_d = MEPC_ADDR;
               csr_wdata_d = bus.trap_pc;
               trap_ack_d  = 1'b1;
               busy_d      = 1'b1;
            end else if (bus.pipe_we) begin
               csr_we_d    = 1'b1;
               csr_waddr_d = bus.pipe_addr;
               csr_wdata_d = bus.pipe_din;
            end else begin
               csr_we_d    = 1'b0;
            end
         end
         W_EPC: begin
            state_d     = W_CAUSE;
            csr_we_d    = 1'b1;
            csr_waddr_d = MCAUSE_ADDR;
            csr_wdata_d = cause_q;
            busy_d      = 1'b1;
         end
         W_CAUSE: begin
            state_d     = W_TVAL;
            csr_we_d    = 1'b1;
            csr_waddr_d = MTVAL_ADDR;
            csr_wdata_d = tval_q;
            trap_done_d = 1'b1;
            busy_d      = 1'b1;
         end
         W_TVAL: begin
            state_d = IDLE;
            // the held pipe write can use the slot right after mtval,
            // unless another trap is already waiting for IDLE
            if (bus.pipe_we && !bus.trap_req) begin
               csr_we_d    = 1'b1;
               csr_waddr_d = bus.pipe_addr;
               csr_wdata_d = bus.pipe_din;
            end else begin
               csr_we_d    = 1'b0;
            end
         end
         default: begin
            state_d  = IDLE;
            csr_we_d = 1'b0;
         end
      endcase
   end

   // State and output registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         csr_we_q    <= 1'b0;
         csr_waddr_q <= {ADDR_W{1'b0}};
         csr_wdata_q <= {DATA_W{1'b0}};
         trap_ack_q  <= 1'b0;
         trap_done_q <= 1'b0;
         busy_q      <= 1'b0;
         cause_q     <= {DATA_W{1'b0}};
         tval_q      <= {DATA_W{1'b0}};
      end else begin
         state_q     <= state_d;
         csr_we_q    <= csr_we_d;
         csr_waddr_q <= csr_waddr_d;
         csr_wdata_q <= csr_wdata_d;
         trap_ack_q  <= trap_ack_d;
         trap_done_q <= trap_done_d;
         busy_q      <= busy_d;
         cause_q     <= cause_d;
         tval_q      <= tval_d;
      end
   end

   assign bus.pipe_stall = bus.pipe_we & ((state_q != IDLE) | bus.trap_req);
   assign bus.csr_we     = csr_we_q;
   assign bus.csr_waddr  = csr_waddr_q;
   assign bus.csr_wdata  = csr_wdata_q;
   assign bus.trap_ack   = trap_ack_q;
   assign bus.trap_done  = trap_done_q;
   assign bus.busy       = busy_q;

`ifdef CSR_RAW_FWD_EN
   // Forward the value on the write port so a same-cycle read sees it
   assign bus.rd_dout = (csr_we_q && (csr_waddr_q == bus.rd_addr)) ? csr_wdata_q : bus.rd_din;
`endif

endmodule

// File: tb/tb_csr_write_sched.sv
// ---------------------------------------------------------------------------
// tb_csr_write_sched
// Directed scenarios followed by randomized traffic. Expected CSR writes are
// derived from the scheduling rules (trap takes the port for three cycles,
// pipe writes land one cycle after acceptance) and pushed, time-stamped, into
// a queue; a negedge monitor pops and compares whenever csr_we is high.
// ---------------------------------------------------------------------------
module tb_csr_write_sched;

   localparam logic [11:0] MEPC   = 12'h341;
   localparam logic [11:0] MCAUSE = 12'h342;
   localparam logic [11:0] MTVAL  = 12'h343;

   typedef struct {
      int          stamp;
      logic [11:0] a;
      logic [31:0] d;
      logic        ack;
      logic        done;
      logic        busy;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   busy_until = -100;   // last cycle whose write belongs to a trap
   bit   last_stall = 1'b0;
   bit   last_trap_acc = 1'b0;
   logic [11:0] last_a = 12'h000;
   logic [31:0] last_d = 32'h0;
   exp_t expq[$];
   logic [11:0] picks [4] = '{12'h300, 12'h341, 12'h342, 12'h343};

   csr_write_sched_if #(.ADDR_W(12), .DATA_W(32)) bus ();

   csr_write_sched dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Scoreboard monitor: compare port activity with the expected write queue
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         last_a = 12'h000;
         last_d = 32'h0;
      end else if (bus.csr_we === 1'b1) begin
         if (expq.size() == 0) begin
            chk("unexpected_write", 32'(bus.csr_waddr), 32'hFFFF_FFFF);
         end else begin
            e = expq.pop_front();
            chk("write_cycle", cyc, e.stamp);
            chk("waddr", 32'(bus.csr_waddr), 32'(e.a));
            chk("wdata", bus.csr_wdata, e.d);
            chk("ack_done_busy", 32'({bus.trap_ack, bus.trap_done, bus.busy}),
                32'({e.ack, e.done, e.busy}));
`ifdef CSR_RAW_FWD_EN
            chk("rd_dout_fwd", bus.rd_dout, (e.a == bus.rd_addr) ? e.d : bus.rd_din);
`endif
            last_a = e.a;
            last_d = e.d;
         end
      end else begin
         if (expq.size() != 0 && expq[0].stamp <= cyc) begin
            e = expq.pop_front();
            chk("missing_write", 32'(bus.csr_we), 32'h1);
         end
         chk("idle_flags", 32'({bus.trap_ack, bus.trap_done, bus.busy}), 32'h0);
         chk("idle_hold_addr", 32'(bus.csr_waddr), 32'(last_a));
         chk("idle_hold_data", bus.csr_wdata, last_d);
`ifdef CSR_RAW_FWD_EN
         chk("rd_dout_pass", bus.rd_dout, bus.rd_din);
`endif
      end
   end

   // One clock cycle: check stall, apply the scheduling rules, cross the edge
   task automatic step();
      logic exp_stall;
      #2;
      exp_stall = bus.pipe_we & ((cyc <= busy_until) | bus.trap_req);
      chk("pipe_stall", 32'(bus.pipe_stall), 32'(exp_stall));
      last_stall    = exp_stall;
      last_trap_acc = 1'b0;
      if (cyc > busy_until && bus.trap_req) begin
         expq.push_back('{cyc + 1, MEPC,   bus.trap_pc,    1'b1, 1'b0, 1'b1});
         expq.push_back('{cyc + 2, MCAUSE, bus.trap_cause, 1'b0, 1'b0, 1'b1});
         expq.push_back('{cyc + 3, MTVAL,  bus.trap_tval,  1'b0, 1'b1, 1'b1});
         busy_until    = cyc + 3;
         last_trap_acc = 1'b1;
      end else if (bus.pipe_we && !bus.trap_req && cyc >= busy_until) begin
         expq.push_back('{cyc + 1, bus.pipe_addr, bus.pipe_din, 1'b0, 1'b0, 1'b0});
      end
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset in the middle of the current cycle
   task automatic reset_mid();
      #2;
      rst = 1'b1;
      #1;
      chk("rst_csr_we", 32'(bus.csr_we), 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_done", 32'(bus.trap_done), 32'h0);
      expq.delete();
      busy_until    = -100;
      last_stall    = 1'b0;
      last_trap_acc = 1'b0;
      bus.trap_req  = 1'b0;
      bus.pipe_we   = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      bus.pipe_we    = 1'b0;
      bus.pipe_addr  = 12'h000;
      bus.pipe_din   = 32'h0;
      bus.trap_req   = 1'b0;
      bus.trap_pc    = 32'h0;
      bus.trap_cause = 32'h0;
      bus.trap_tval  = 32'h0;
`ifdef CSR_RAW_FWD_EN
      bus.rd_addr    = 12'h000;
      bus.rd_din     = 32'h0;
`endif
      #1;
      rst = 1'b1;
      #2;
      chk("reset_outputs", 32'({bus.csr_we, bus.trap_ack, bus.trap_done, bus.busy}), 32'h0);
      chk("reset_waddr", 32'(bus.csr_waddr), 32'h0);
      chk("reset_wdata", bus.csr_wdata, 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step();

      // single pipeline write
`ifdef CSR_RAW_FWD_EN
      bus.rd_addr = 12'h300;
      bus.rd_din  = 32'hABC;
`endif
      bus.pipe_we = 1'b1; bus.pipe_addr = 12'h300; bus.pipe_din = 32'h8;
      step();
      bus.pipe_we = 1'b0;
      step();
      step();

      // basic trap sequence; ID stage reads mcause while it is being written
`ifdef CSR_RAW_FWD_EN
      bus.rd_addr = 12'h342;
      bus.rd_din  = 32'h0;
`endif
      bus.trap_req = 1'b1; bus.trap_pc = 32'h100; bus.trap_cause = 32'h2; bus.trap_tval = 32'hDEAD;
      step();
      bus.trap_req = 1'b0;
      for (int k = 0; k < 4; k++) step();

      // trap and pipe write to mepc in the same cycle
      bus.trap_req = 1'b1; bus.trap_pc = 32'h100; bus.trap_cause = 32'h2; bus.trap_tval = 32'hDEAD;
      bus.pipe_we = 1'b1; bus.pipe_addr = 12'h341; bus.pipe_din = 32'h55;
      step();
      bus.trap_req = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (!last_stall) bus.pipe_we = 1'b0;
         step();
      end

      // operand change after acceptance, trap_req held high -> second sequence
      bus.trap_req = 1'b1; bus.trap_pc = 32'h100;
      step();
      bus.trap_pc = 32'h999;
      for (int k = 0; k < 4; k++) step();
      bus.trap_req = 1'b0;
      for (int k = 0; k < 4; k++) step();

      // reset during W_CAUSE
      bus.trap_req = 1'b1; bus.trap_pc = 32'h111; bus.trap_cause = 32'h7; bus.trap_tval = 32'h77;
      step();
      bus.trap_req = 1'b0;
      step();
      chk("pre_rst_cause_write", 32'({bus.csr_we, bus.busy}), 32'h3);
      reset_mid();
      for (int k = 0; k < 4; k++) step();

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         if (i == 300) begin
            reset_mid();
         end else begin
            if (last_trap_acc) bus.trap_req = ($urandom_range(0, 3) == 0);
            else if (!bus.trap_req) bus.trap_req = ($urandom_range(0, 5) == 0);
            bus.trap_pc    = $urandom;
            bus.trap_cause = $urandom;
            bus.trap_tval  = $urandom;
            if (!(bus.pipe_we && last_stall)) begin
               bus.pipe_we   = ($urandom_range(0, 1) == 1);
               bus.pipe_addr = picks[$urandom_range(0, 3)];
               bus.pipe_din  = $urandom;
            end
`ifdef CSR_RAW_FWD_EN
            bus.rd_addr = picks[$urandom_range(0, 3)];
            bus.rd_din  = $urandom;
`endif
            step();
         end
      end

      // drain
      bus.trap_req = 1'b0;
      bus.pipe_we  = 1'b0;
      for (int k = 0; k < 6; k++) step();
      chk("queue_drained", expq.size(), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
